// File: rtl/adc_capture_ctrl.sv
// Triggered recorder for 8x12-bit ADC frames: arm, trigger, optional delay, decimated
// capture of sign-extended 16-bit channels into 128-bit RAM words.
module adc_capture_ctrl #(
    parameter int ADDR_W     = 14,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic              frame_clk,
    input  logic              reset,
    input  logic [95:0]       data_in,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic [15:0]       delay,
    input  logic [ADDR_W:0]   rec_len,
    input  logic [3:0]        decim,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_data,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_RECORD,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [15:0]     delay_reg;
    logic [15:0]     dly_cnt_reg;
    logic [ADDR_W:0] len_reg;
    logic [3:0]      decim_reg;
    logic [3:0]      dec_cnt_reg;
    logic [127:0]    fmt_data;

    // Offset binary becomes two's complement by flipping the MSB before sign extension.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fmt
            logic [11:0] x_slice;
            assign x_slice = data_in[12*gi +: 12] ^ {OFFSET_BIN, 11'b0};
            assign fmt_data[16*gi +: 16] = {{4{x_slice[11]}}, x_slice};
        end
    endgenerate

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            delay_reg     <= '0;
            len_reg       <= '0;
            decim_reg     <= '0;
            dly_cnt_reg   <= '0;
            dec_cnt_reg   <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            armed         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            wr_en <= 1'b0;
            if (abort) begin
                // Dropping the capture here also cancels the write it would have produced.
                state_reg <= ST_IDLE;
                armed     <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            delay_reg     <= delay;
                            decim_reg     <= decim;
                            len_reg       <= (rec_len > MAX_LEN) ? MAX_LEN : rec_len;
                            words_written <= '0;
                            state_reg     <= ST_ARMED;
                            armed         <= 1'b1;
                            done          <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (trigger) begin
                            armed       <= 1'b0;
                            dly_cnt_reg <= 16'd1;
                            dec_cnt_reg <= '0;
                            if (len_reg == '0) begin
                                state_reg <= ST_DONE;
                                done      <= 1'b1;
                            end else begin
                                busy      <= 1'b1;
                                state_reg <= (delay_reg != '0) ? ST_DELAY : ST_RECORD;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (dly_cnt_reg == delay_reg) begin
                            state_reg <= ST_RECORD;
                        end else begin
                            dly_cnt_reg <= dly_cnt_reg + 16'd1;
                        end
                    end
                    ST_RECORD: begin
                        dec_cnt_reg <= (dec_cnt_reg == decim_reg) ? 4'd0 : dec_cnt_reg + 4'd1;
                        if (dec_cnt_reg == 4'd0) begin
                            wr_en         <= 1'b1;
                            wr_addr       <= words_written[ADDR_W-1:0];
                            wr_data       <= fmt_data;
                            words_written <= words_written + 1'b1;
                            // The final capture lands in DONE together with its write strobe.
                            if (words_written + 1'b1 == len_reg) begin
                                state_reg <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed sequence with random frame data, checked every
// cycle against a schedule-based reference model of writes and status windows.
module tb_adc_capture_ctrl;

    localparam int ADDR_W  = 7;
    localparam int MAXW    = 1 << ADDR_W;
    localparam int BIG     = 32'h3FFF_FFFF;

    logic              frame_clk = 1'b0;
    logic              reset;
    logic [95:0]       data_in;
    logic              arm, trigger, abort;
    logic [15:0]       delay;
    logic [ADDR_W:0]   rec_len;
    logic [3:0]        decim;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [127:0]      wr_data;
    logic              armed, busy, done;
    logic [ADDR_W:0]   words_written;

    adc_capture_ctrl #(.ADDR_W(ADDR_W), .OFFSET_BIN(1'b1)) dut (
        .frame_clk     (frame_clk),
        .reset         (reset),
        .data_in       (data_in),
        .arm           (arm),
        .trigger       (trigger),
        .abort         (abort),
        .delay         (delay),
        .rec_len       (rec_len),
        .decim         (decim),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .armed         (armed),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int wcyc;
        int addr;
        int ccyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [95:0] hist[int];
    int cyc = 0;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int arm_lo = 1, arm_hi = 0, busy_lo = 1, busy_hi = 0, done_lo = 1, done_hi = 0;
    int ww_exp = 0;
    int lat_d = 0, lat_len = 0, lat_dec = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic bit inw(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Each channel as a signed integer, then written back as 16-bit two's complement.
    function automatic logic [127:0] fmt(input logic [95:0] d);
        logic [127:0] r;
        int x;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            x = int'((d >> (12 * k)) & 96'hFFF);
            x = x ^ 'h800;
            if (x >= 2048) x = x - 4096;
            r[16*k +: 16] = 16'(x);
        end
        return r;
    endfunction

    function automatic logic [95:0] rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [95:0] ramp(input int n);
        logic [11:0] v;
        v = 12'(n);
        return {8{v}};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        arm_lo = 1; arm_hi = 0; busy_lo = 1; busy_hi = 0; done_lo = 1; done_hi = 0;
        ww_exp = 0; lat_d = 0; lat_len = 0; lat_dec = 0;
    endtask

    task automatic model_trigger(input int t);
        int c0, cap;
        arm_hi = t;
        if (lat_len == 0) begin
            done_lo = t + 1; done_hi = BIG;
        end else begin
            c0 = (lat_d == 0) ? t + 1 : t + lat_d + 1;
            cap = c0;
            for (int k = 0; k < lat_len; k++) begin
                cap = c0 + k * (lat_dec + 1);
                exp_q.push_back('{cap + 1, k, cap});
            end
            busy_lo = t + 1; busy_hi = cap;
            done_lo = cap + 1; done_hi = BIG;
        end
    endtask

    task automatic model_abort(input int a);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].ccyc >= a) exp_q.delete(i);
        if (arm_hi > a) arm_hi = a;
        if (busy_hi > a) busy_hi = a;
        if (done_hi > a) done_hi = a;
    endtask

    task automatic check_cycle();
        bit ew;
        ew = (exp_q.size() > 0) && (exp_q[0].wcyc == cyc);
        if (ew) ww_exp++;
        chk("wr_en", 128'(wr_en), 128'(ew));
        if (ew) begin
            chk("wr_addr", 128'(wr_addr), 128'(exp_q[0].addr));
            chk("wr_data", wr_data, fmt(hist[exp_q[0].ccyc]));
            void'(exp_q.pop_front());
        end
        chk("armed", 128'(armed), 128'(inw(cyc, arm_lo, arm_hi)));
        chk("busy", 128'(busy), 128'(inw(cyc, busy_lo, busy_hi)));
        chk("done", 128'(done), 128'(inw(cyc, done_lo, done_hi)));
        chk("words_written", 128'(words_written), 128'(ww_exp));
    endtask

    // One frame: apply inputs, update the model from them, clock, then check outputs.
    task automatic step(input logic [95:0] d);
        bit idle_or_done;
        int len;
        data_in = d;
        hist[cyc] = d;
        idle_or_done = !inw(cyc, arm_lo, arm_hi) && !inw(cyc, busy_lo, busy_hi);
        if (!reset) begin
            if (abort) begin
                model_abort(cyc);
            end else if (arm && idle_or_done) begin
                len = int'(rec_len);
                lat_len = (len > MAXW) ? MAXW : len;
                lat_d = int'(delay);
                lat_dec = int'(decim);
                arm_lo = cyc + 1; arm_hi = BIG;
                if (done_hi > cyc) done_hi = cyc;
                ww_exp = 0;
            end else if (trigger && inw(cyc, arm_lo, arm_hi)) begin
                model_trigger(cyc);
            end
        end
        @(posedge frame_clk);
        cyc++;
        @(negedge frame_clk);
        check_cycle();
        arm = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_out();
        for (int i = 0; i < 600 && exp_q.size() > 0; i++) step(rnd());
        repeat (2) step(rnd());
    endtask

    task automatic record(input int d, input int len, input int dec);
        delay = 16'(d); rec_len = (ADDR_W + 1)'(len); decim = 4'(dec);
        arm = 1'b1;
        step(rnd());
        repeat ($urandom_range(0, 3)) step(rnd());
        trigger = 1'b1;
        step(rnd());
        trigger = 1'b0;
        run_out();
    endtask

    initial begin
        reset = 1'b1; arm = 0; trigger = 0; abort = 0; data_in = '0;
        delay = '0; rec_len = '0; decim = '0;
        repeat (3) @(posedge frame_clk);
        @(negedge frame_clk);
        chk("rst_wr_en", 128'(wr_en), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_wr_data", wr_data, 128'(0));
        chk("rst_armed", 128'(armed), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_words", 128'(words_written), 128'(0));
        reset = 1'b0;

        // Trigger while idle must not start anything.
        trigger = 1'b1;
        repeat (3) step(rnd());
        trigger = 1'b0;

        // Basic record with ramp data, no delay, no decimation.
        delay = 0; rec_len = 4; decim = 0; arm = 1'b1;
        step(ramp(cyc));
        repeat (2) step(ramp(cyc));
        trigger = 1'b1;
        step(ramp(cyc));
        trigger = 1'b0;
        repeat (8) step(ramp(cyc));
        chk("basic_done", 128'(done), 128'(1));
        chk("basic_words", 128'(words_written), 128'(4));

        // Delay and decimation.
        record(5, 3, 2);
        chk("dly_words", 128'(words_written), 128'(3));

        // Zero length.
        record(4, 0, 1);
        chk("zero_done", 128'(done), 128'(1));
        chk("zero_words", 128'(words_written), 128'(0));

        // Abort after the 20th write.
        delay = 0; rec_len = 100; decim = 0; arm = 1'b1;
        step(rnd());
        trigger = 1'b1;
        step(rnd());
        trigger = 1'b0;
        for (int i = 0; i < 200 && ww_exp < 20; i++) step(rnd());
        abort = 1'b1;
        step(rnd());
        repeat (5) step(rnd());
        chk("abort_words", 128'(words_written), 128'(20));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));

        // Simultaneous arm+trigger in IDLE, then a held trigger and an arm during RECORD.
        delay = 3; rec_len = 10; decim = 1; arm = 1'b1; trigger = 1'b1;
        step(rnd());
        chk("simul_armed", 128'(armed), 128'(1));
        chk("simul_busy", 128'(busy), 128'(0));
        repeat (7) step(rnd());
        delay = 0; rec_len = 50; decim = 0; arm = 1'b1;
        step(rnd());
        run_out();
        trigger = 1'b0;
        step(rnd());
        chk("ign_words", 128'(words_written), 128'(10));

        // Length clamp to the full RAM.
        record($urandom_range(0, 4), 255, 0);
        chk("clamp_words", 128'(words_written), 128'(MAXW));

        // Random records.
        for (int r = 0; r < 5; r++)
            record($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 3));

        // Asynchronous reset in the middle of a record.
        delay = 0; rec_len = 20; decim = 0; arm = 1'b1;
        step(rnd());
        trigger = 1'b1;
        step(rnd());
        trigger = 1'b0;
        repeat (6) step(rnd());
        chk("pre_reset_wr_en", 128'(wr_en), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("areset_wr_en", 128'(wr_en), 128'(0));
        chk("areset_busy", 128'(busy), 128'(0));
        chk("areset_words", 128'(words_written), 128'(0));
        model_reset();
        step(rnd());
        reset = 1'b0;
        trigger = 1'b1;
        repeat (3) step(rnd());
        trigger = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Triggered sample recorder downstream of the 8-channel LVDS deserializer. It takes the 96-bit parallel frame (8 channels × 12 bits) produced every frame clock and waits for an armed trigger. It then skips a programmable delay, decimates, formats each channel to 16 bits and issues one 128-bit write per kept frame into the acquisition RAM, stopping after a programmed length.

## Interface
Parameters:
- ADDR_W, 14: RAM address width; the maximum record is 2^ADDR_W words.
- OFFSET_BIN, 1: 1 means inputs are offset binary (MSB is inverted before sign extension); 0 means inputs are already two's complement.

Ports:
- frame_clk  in  1  sole clock; one ADC frame per cycle.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  96  channel k occupies bits [12k+11:12k].
- arm  in  1  pulse; moves IDLE/DONE to ARMED.
- trigger  in  1  level; sampled only in ARMED.
- abort  in  1  pulse; forces IDLE from any state.
- delay  in  16  frames skipped after the trigger.
- rec_len  in  ADDR_W+1  number of words to write (0 to 2^ADDR_W).
- decim  in  4  keep 1 of every decim+1 frames.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM word address.
- wr_data  out  128  channel k at [16k+15:16k], sign-extended.
- armed  out  1  high in ARMED.
- busy  out  1  high in DELAY or RECORD.
- done  out  1  high in DONE.
- words_written  out  ADDR_W+1  write count for the current or last record.

## Operation
- States:
  - IDLE: arm → ARMED.
  - ARMED: trigger=1 → DELAY if delay≠0, otherwise RECORD.
  - DELAY: counts delay frames, then → RECORD.
  - RECORD: after rec_len writes → DONE.
  - DONE: arm → ARMED.
- Configuration latch: delay, rec_len and decim are captured when arm is accepted. Later changes have no effect until the next arm.
- rec_len=0: the trigger takes the block directly to DONE with no writes, and the delay is skipped.
- rec_len > 2^ADDR_W is clamped to 2^ADDR_W at latch time.
- Decimation counter: reset to 0 on entry to RECORD. A frame is captured when the counter is 0. The counter counts 0..decim and wraps.
- Formatting, per channel: x = data_in slice. When OFFSET_BIN=1, x[11] is inverted first. Then wr_data slice = {{4{x[11]}}, x}.
- Addressing: wr_addr starts at 0 on each record and increments by 1 per write. words_written is cleared on arm acceptance and increments with each wr_en.
- Ignored inputs:
  - arm in DELAY or RECORD.
  - trigger outside ARMED.
- abort:
  - In any state: the next state is IDLE, and a capture pending in the pipeline is dropped (no wr_en).
  - words_written holds its value.
  - abort takes priority over a simultaneous arm or trigger.
- Simultaneous arm and trigger in IDLE: only the arm is accepted. The trigger must be high in a later cycle.

## Timing
- Reset values:
  - state IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - armed=busy=done=0.
  - words_written=0.
  - latched configuration=0.
- Reset is asynchronous and takes effect mid-record; no further writes occur.
- arm accepted at cycle a → armed=1 at a+1.
- Trigger seen at cycle t:
  - delay=D≠0: DELAY spans cycles t+1..t+D, and RECORD starts at t+D+1.
  - D=0: RECORD starts at t+1.
- Write pipeline: a frame captured at cycle c drives wr_en=1 with its wr_data and wr_addr at c+1, for exactly one cycle.
- Last capture at cycle c: the state is DONE at c+1, coinciding with the final wr_en. done=1 and busy=0 from c+1.
- Throughput: at most one write per cycle (decim=0). Writes are spaced decim+1 cycles apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic record, OFFSET_BIN=1: D=0, rec_len=4, decim=0; data_in ramps so every channel = n at cycle n; trigger at cycle 10.
  - Expect wr_en at cycles 12–15.
  - Expect wr_addr 0–3.
  - Channel 0 of the first word = (11 ^ 0x800) sign-extended = 0xF80B.
  - done=1 at cycle 15.
- Delay and decimation: D=5, decim=2, rec_len=3, trigger at t. Expect captures at t+6, t+9, t+12, wr_en at t+7, t+10, t+13, and words_written=3.
- Zero length: rec_len=0, then trigger. Expect DONE at t+1, no wr_en, words_written=0.
- Abort mid-record: rec_len=100, abort after the 20th wr_en. Expect no further wr_en, state IDLE, words_written=20, done=0.
- Ignored events:
  - Trigger while IDLE gives no busy.
  - arm during RECORD does not change rec_len or wr_addr.
  - Simultaneous arm and trigger in IDLE gives armed=1 only.
- Clamp and async reset: ADDR_W=4, rec_len=31 gives 16 writes with wr_addr wrapping nowhere (0–15). Asserting reset between clock edges mid-record gives immediate wr_en=0 and IDLE.
